// File: rtl/vid_mem_scheduler.sv
// Frame-buffer RAM arbiter: interleaves CPU accesses with per-line video
// fetches into a small word FIFO drained by the pixel shifter.
module vid_mem_scheduler #(
    parameter int                ADDR_W         = 17,
    parameter logic [ADDR_W-1:0] FB_BASE        = '0,
    parameter int                WORDS_PER_LINE = 32,
    parameter int                LINES          = 342,
    parameter int                FIFO_DEPTH     = 4,
    parameter int                VID_BURST      = 4
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              line_start,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [15:0]       cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic              vid_valid,
    output logic [15:0]       vid_word,
    input  logic              vid_ready,
    output logic              underrun
);

    localparam int WL_W  = $clog2(WORDS_PER_LINE + 1);
    localparam int LC_W  = $clog2(LINES + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ST_W  = $clog2(VID_BURST + 1);

    typedef enum logic [1:0] {
        IDLE,
        VID,
        CPU
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] ptr;
    logic [WL_W-1:0]   words_left;
    logic [LC_W-1:0]   line_cnt;
    logic [ST_W-1:0]   streak;
    logic              drop;

    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic vid_want;
    logic cpu_first;
    logic grant_vid;
    logic grant_cpu;
    logic push;
    logic pop;
    logic line_ok;

    assign vid_want  = (words_left != '0)
                     && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign cpu_first = cpu_req && (streak == ST_W'(VID_BURST));
    assign grant_vid = (state == IDLE) && (state_nxt == VID);
    assign grant_cpu = (state == IDLE) && (state_nxt == CPU);
    assign line_ok   = line_start
                     && (frame_start || (line_cnt < LC_W'(LINES)));

    // State register
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one grant per idle cycle, CPU forced after a full burst
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cpu_first) begin
                    state_nxt = CPU;
                end else if (vid_want) begin
                    state_nxt = VID;
                end else if (cpu_req) begin
                    state_nxt = CPU;
                end
            end
            VID, CPU: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        mem_req   = (state != IDLE);
        cpu_ack   = (state == CPU) && mem_ack;
        cpu_rdata = mem_rdata;
        push      = (state == VID) && mem_ack && !drop && !frame_start;
        vid_valid = (fifo_count != '0);
        pop       = vid_valid && vid_ready;
        vid_word  = fifo_mem[rd_ptr];
    end

    // Bus request registers and arbitration history
    always_ff @(posedge clk_in) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            streak    <= '0;
            drop      <= 1'b0;
        end else begin
            if (grant_vid) begin
                mem_addr  <= ptr;
                mem_we    <= 1'b0;
                mem_wdata <= '0;
                if (streak != ST_W'(VID_BURST)) begin
                    streak <= streak + 1'b1;
                end
            end else if (grant_cpu) begin
                mem_addr  <= cpu_addr;
                mem_we    <= cpu_we;
                mem_wdata <= cpu_wdata;
                streak    <= '0;
            end
            // A fetch outstanding across frame_start belongs to the old frame
            if (state_nxt != VID) begin
                drop <= 1'b0;
            end else if (frame_start) begin
                drop <= 1'b1;
            end
        end
    end

    // Line/frame sequencing
    always_ff @(posedge clk_in) begin
        if (rst) begin
            ptr        <= FB_BASE;
            words_left <= '0;
            line_cnt   <= '0;
            underrun   <= 1'b0;
        end else begin
            underrun <= line_start && !frame_start
                     && (line_cnt < LC_W'(LINES))
                     && (words_left != '0);
            if (push) begin
                ptr        <= ptr + 1'b1;
                words_left <= words_left - 1'b1;
            end
            if (frame_start) begin
                ptr        <= FB_BASE;
                words_left <= '0;
                line_cnt   <= '0;
            end
            if (line_ok) begin
                words_left <= WL_W'(WORDS_PER_LINE);
                if (frame_start) begin
                    line_cnt <= LC_W'(1);
                end else begin
                    line_cnt <= line_cnt + 1'b1;
                end
            end
        end
    end

    // Video word FIFO
    always_ff @(posedge clk_in) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (frame_start) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

endmodule
